// File: rtl/config_seq_ctrl_if.sv
// config_seq_ctrl_if: host request/response, sweep control and core config bus of config_seq_ctrl.
interface config_seq_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        sweep_start;
    logic [31:0] sweep_data;
    logic        sweep_busy;
    logic        sweep_done;
    logic [7:0]  config_config_addr;
    logic [31:0] config_config_data;
    logic        config_write;
    logic        config_read;
    logic [31:0] read_config_data;
    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready, sweep_start, sweep_data, read_config_data,
        input  req_ready, rsp_valid, rsp_data, sweep_busy, sweep_done,
               config_config_addr, config_config_data, config_write, config_read
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready, sweep_start, sweep_data, read_config_data,
        output req_ready, rsp_valid, rsp_data, sweep_busy, sweep_done,
               config_config_addr, config_config_data, config_write, config_read
    );
endinterface

// File: rtl/config_seq_ctrl.sv
// config_seq_ctrl: sequences host reads/writes and full-range write sweeps onto a config register core.
module config_seq_ctrl #(
    parameter int NUM_REGS = 2,
    parameter int READ_LAT = 1
) (
    input logic               real_clk,
    input logic               real_rst,
    config_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, SWEEP} state_t;
    localparam logic [7:0] LAST_ADDR = 8'(NUM_REGS - 1);
    localparam logic [1:0] LAST_LAT  = 2'(READ_LAT - 1);
    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d, rsp_data_q, rsp_data_d;
    logic [1:0]  lat_q, lat_d;
    logic        wr_q, wr_d, rd_q, rd_d, rsp_valid_q, rsp_valid_d, busy_q, busy_d, done_q, done_d;
    assign bus.req_ready          = (state_q == IDLE) && !bus.sweep_start;
    assign bus.rsp_valid          = rsp_valid_q;
    assign bus.rsp_data           = rsp_data_q;
    assign bus.sweep_busy         = busy_q;
    assign bus.sweep_done         = done_q;
    assign bus.config_config_addr = addr_q;
    assign bus.config_config_data = data_q;
    assign bus.config_write       = wr_q;
    assign bus.config_read        = rd_q;
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        lat_d       = lat_q;
        wr_d        = 1'b0;
        rd_d        = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                // a sweep request pre-empts a host request in the same cycle
                if (bus.sweep_start) begin
                    state_d = SWEEP;
                    addr_d  = 8'd0;
                    data_d  = bus.sweep_data;
                    wr_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    lat_d   = 2'd0;
                    state_d = bus.req_write ? WRITE : READ;
                    data_d  = bus.req_write ? bus.req_data : data_q;
                    wr_d    = bus.req_write;
                    rd_d    = !bus.req_write;
                end
            end
            WRITE: state_d = IDLE;
            READ: begin
                if (lat_q == LAST_LAT) begin
                    rsp_data_d  = bus.read_config_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    lat_d = lat_q + 2'd1;
                    rd_d  = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            SWEEP: begin
                // the counter stops at the last register, so 256 registers end at 0xFF without wrapping
                if (addr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d = addr_q + 8'd1;
                    wr_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            lat_q       <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            lat_q       <= lat_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_config_seq_ctrl.sv
// tb_config_seq_ctrl: scoreboard bench for config_seq_ctrl with a register-file core model.
module tb_config_seq_ctrl;
    localparam int NR = 2;
    logic real_clk = 1'b0;
    logic real_rst = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [39:0] wq[$];
    logic [31:0] rq[$];
    logic [31:0] shadow [256];
    logic [31:0] mem [256];
    logic [31:0] mem3 [256];
    logic rsp_seen = 1'b0;
    logic [31:0] rsp_hold = '0;
    config_seq_ctrl_if bus ();
    config_seq_ctrl_if bus3 ();
    config_seq_ctrl #(.NUM_REGS(NR), .READ_LAT(1)) dut (.real_clk(real_clk), .real_rst(real_rst), .bus(bus));
    config_seq_ctrl #(.NUM_REGS(NR), .READ_LAT(3)) dut3 (.real_clk(real_clk), .real_rst(real_rst), .bus(bus3));
    always #5 real_clk = ~real_clk;
    assign bus.read_config_data  = bus.config_read ? mem[bus.config_config_addr] : 32'h0;
    assign bus3.read_config_data = bus3.config_read ? mem3[bus3.config_config_addr] : 32'h0;
    always @(posedge real_clk) begin
        if (bus.config_write) mem[bus.config_config_addr] <= bus.config_config_data;
        if (bus3.config_write) mem3[bus3.config_config_addr] <= bus3.config_config_data;
    end
    task automatic tick();
        logic [39:0] e;
        @(posedge real_clk);
        #1;
        if (bus.config_write) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL core_write unexpected: got addr=%h data=%h, none required", bus.config_config_addr, bus.config_config_data);
            end else begin
                e = wq.pop_front();
                if ({bus.config_config_addr, bus.config_config_data} !== e) begin
                    errors++;
                    $display("FAIL core_write: got %h/%h required %h/%h", bus.config_config_addr, bus.config_config_data, e[39:32], e[31:0]);
                end
            end
        end
        checks++;
        if (bus.config_write && bus.config_read) begin
            errors++;
            $display("FAIL strobe_excl: got write=1 read=1 required not both");
        end
        if (bus.rsp_valid && !rsp_seen) begin
            checks++;
            rsp_seen = 1'b1;
            rsp_hold = bus.rsp_data;
            if (rq.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got %h, none required", bus.rsp_data);
            end else if (bus.rsp_data !== rq[0]) begin
                errors++;
                $display("FAIL rsp_data: got %h required %h", bus.rsp_data, rq[0]);
                void'(rq.pop_front());
            end else void'(rq.pop_front());
        end else if (bus.rsp_valid) begin
            checks++;
            if (bus.rsp_data !== rsp_hold) begin
                errors++;
                $display("FAIL rsp_stable: got %h required %h", bus.rsp_data, rsp_hold);
            end
        end
        if (!bus.rsp_valid) rsp_seen = 1'b0;
    endtask
    task automatic wait_ready();
        for (int i = 0; i < 30 && !bus.req_ready; i++) tick();
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL ready_timeout: got req_ready=0 required 1");
        end
    endtask
    task automatic do_write(input logic [7:0] a, input logic [31:0] d);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        wq.push_back({a, d});
        shadow[a] = d;
        tick();
        bus.req_valid = 1'b0;
    endtask
    task automatic do_read(input logic [7:0] a);
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = a;
        rq.push_back(shadow[a]);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && rq.size() != 0; i++) tick();
        checks++;
        if (rq.size() != 0) begin
            errors++;
            $display("FAIL read_timeout: got %0d pending required 0", rq.size());
            rq.delete();
        end
    endtask
    task automatic do_sweep(input logic [31:0] d);
        wait_ready();
        bus.sweep_start = 1'b1;
        bus.sweep_data  = d;
        for (int k = 0; k < NR; k++) begin
            wq.push_back({8'(k), d});
            shadow[k] = d;
        end
        tick();
        bus.sweep_start = 1'b0;
        for (int i = 0; i < NR + 5 && !bus.sweep_done; i++) tick();
        checks++;
        if (!bus.sweep_done) begin
            errors++;
            $display("FAIL sweep_timeout: got sweep_done=0 required 1");
        end
    endtask
    task automatic test_reset();
        checks++;
        if ({bus.rsp_valid, bus.config_write, bus.config_read, bus.sweep_busy, bus.sweep_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000", {bus.rsp_valid, bus.config_write, bus.config_read, bus.sweep_busy, bus.sweep_done});
        end
        checks++;
        if ({bus.config_config_addr, bus.config_config_data, bus.rsp_data} !== 72'h0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%h/%h required 0", bus.config_config_addr, bus.config_config_data, bus.rsp_data);
        end
        real_rst = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h10;
        bus.req_data  = 32'h11111111;
        wq.push_back({8'h10, 32'h11111111});
        shadow[8'h10] = 32'h11111111;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.config_write !== 1'b1) begin
            errors++;
            $display("FAIL first_accept: got config_write=%b required 1", bus.config_write);
        end
    endtask
    task automatic test_write();
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h01;
        bus.req_data  = 32'hDEADBEEF;
        wq.push_back({8'h01, 32'hDEADBEEF});
        shadow[1] = 32'hDEADBEEF;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.config_write, bus.req_ready, bus.config_config_addr, bus.config_config_data} !== {2'b10, 8'h01, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL write_n1: got wr=%b rdy=%b %h/%h required wr=1 rdy=0 01/deadbeef", bus.config_write, bus.req_ready, bus.config_config_addr, bus.config_config_data);
        end
        tick();
        checks++;
        if ({bus.config_write, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL write_n2: got wr=%b rdy=%b required wr=0 rdy=1", bus.config_write, bus.req_ready);
        end
    endtask
    task automatic test_read();
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h01;
        rq.push_back(32'hDEADBEEF);
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.config_read, bus.rsp_valid, bus.config_config_addr} !== {2'b10, 8'h01}) begin
            errors++;
            $display("FAIL read_n1: got rd=%b vld=%b addr=%h required rd=1 vld=0 addr=01", bus.config_read, bus.rsp_valid, bus.config_config_addr);
        end
        tick();
        checks++;
        if ({bus.config_read, bus.rsp_valid, bus.rsp_data} !== {2'b01, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL read_n2: got rd=%b vld=%b data=%h required rd=0 vld=1 deadbeef", bus.config_read, bus.rsp_valid, bus.rsp_data);
        end
        tick();
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_done: got vld=%b rdy=%b required vld=0 rdy=1", bus.rsp_valid, bus.req_ready);
        end
    endtask
    task automatic test_backpressure();
        do_write(8'h05, 32'h12345678);
        wait_ready();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h05;
        rq.push_back(32'h12345678);
        tick();
        bus.req_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.rsp_valid, bus.req_ready, bus.rsp_data} !== {2'b10, 32'h12345678}) begin
                errors++;
                $display("FAIL rsp_hold: got vld=%b rdy=%b data=%h required vld=1 rdy=0 12345678", bus.rsp_valid, bus.req_ready, bus.rsp_data);
            end
        end
        bus.rsp_ready = 1'b1;
        tick();
        checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rsp_release: got vld=%b rdy=%b required vld=0 rdy=1", bus.rsp_valid, bus.req_ready);
        end
    endtask
    task automatic test_sweep();
        do_write(8'h00, 32'hAAAAAAAA);
        do_write(8'h01, 32'hBBBBBBBB);
        wait_ready();
        bus.sweep_start = 1'b1;
        bus.sweep_data  = 32'h0;
        bus.req_valid   = 1'b1;
        bus.req_write   = 1'b1;
        bus.req_addr    = 8'h07;
        bus.req_data    = 32'h5A5A5A5A;
        for (int k = 0; k < NR; k++) begin
            wq.push_back({8'(k), 32'h0});
            shadow[k] = 32'h0;
        end
        #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL sweep_prio: got req_ready=%b required 0", bus.req_ready);
        end
        tick();
        bus.sweep_start = 1'b0;
        bus.sweep_data  = 32'hFFFFFFFF;
        checks++;
        if ({bus.sweep_busy, bus.req_ready, bus.config_config_addr} !== {2'b10, 8'h00}) begin
            errors++;
            $display("FAIL sweep_w0: got busy=%b rdy=%b addr=%h required busy=1 rdy=0 addr=00", bus.sweep_busy, bus.req_ready, bus.config_config_addr);
        end
        tick();
        checks++;
        if ({bus.sweep_busy, bus.config_write, bus.config_config_addr} !== {2'b11, 8'h01}) begin
            errors++;
            $display("FAIL sweep_w1: got busy=%b wr=%b addr=%h required busy=1 wr=1 addr=01", bus.sweep_busy, bus.config_write, bus.config_config_addr);
        end
        wq.push_back({8'h07, 32'h5A5A5A5A});
        shadow[7] = 32'h5A5A5A5A;
        tick();
        checks++;
        if ({bus.sweep_done, bus.sweep_busy, bus.config_write, bus.req_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL sweep_done: got done=%b busy=%b wr=%b rdy=%b required 1 0 0 1", bus.sweep_done, bus.sweep_busy, bus.config_write, bus.req_ready);
        end
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if ({bus.sweep_done, bus.config_write} !== 2'b01) begin
            errors++;
            $display("FAIL sweep_pending: got done=%b wr=%b required done=0 wr=1", bus.sweep_done, bus.config_write);
        end
        do_read(8'h00);
        do_read(8'h01);
        do_read(8'h07);
    endtask
    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0, 1: do_write(8'($urandom_range(0, 7)), $urandom);
                2, 3: do_read(8'($urandom_range(0, 7)));
                default: do_sweep($urandom);
            endcase
        end
    endtask
    task automatic test_reset_midread();
        bus3.req_valid = 1'b1;
        bus3.req_write = 1'b0;
        bus3.req_addr  = 8'h02;
        tick();
        bus3.req_valid = 1'b0;
        tick();
        checks++;
        if (bus3.config_read !== 1'b1) begin
            errors++;
            $display("FAIL l3_read_held: got config_read=%b required 1", bus3.config_read);
        end
        #2;
        real_rst = 1'b1;
        #1;
        checks++;
        if ({bus3.config_read, bus3.rsp_valid, bus3.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL l3_async_rst: got rd=%b vld=%b rdy=%b required 0 0 1", bus3.config_read, bus3.rsp_valid, bus3.req_ready);
        end
        tick();
        real_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus3.config_read, bus3.rsp_valid, bus3.config_write} !== 3'b000) begin
                errors++;
                $display("FAIL l3_post_rst: got rd=%b vld=%b wr=%b required 0 0 0", bus3.config_read, bus3.rsp_valid, bus3.config_write);
            end
        end
        bus3.req_valid = 1'b1;
        bus3.req_write = 1'b1;
        bus3.req_addr  = 8'h03;
        bus3.req_data  = 32'hCAFEF00D;
        tick();
        bus3.req_valid = 1'b0;
        checks++;
        if ({bus3.config_write, bus3.config_config_addr, bus3.config_config_data} !== {1'b1, 8'h03, 32'hCAFEF00D}) begin
            errors++;
            $display("FAIL l3_write: got wr=%b %h/%h required wr=1 03/cafef00d", bus3.config_write, bus3.config_config_addr, bus3.config_config_data);
        end
    endtask
    initial begin
        for (int i = 0; i < 256; i++) begin
            shadow[i] = '0;
            mem[i]    = '0;
            mem3[i]   = '0;
        end
        {bus.req_valid, bus.req_write, bus.req_addr, bus.req_data, bus.sweep_start, bus.sweep_data} = '0;
        {bus3.req_valid, bus3.req_write, bus3.req_addr, bus3.req_data, bus3.sweep_start, bus3.sweep_data} = '0;
        bus.rsp_ready  = 1'b1;
        bus3.rsp_ready = 1'b1;
        repeat (3) @(posedge real_clk);
        #1;
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_sweep();
        test_random();
        test_reset_midread();
        checks++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d writes %0d reads pending required 0", wq.size(), rq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
